seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Decodes a scanned 4-digit active-low 7-segment bus back into character codes and frames.
// Latency: a digit is captured after SETTLE_CYCLES identical samples; the frame strobe follows the fourth capture by two cycles.
// Backpressure: none; this is a passive monitor, and a partial frame is dropped after TIMEOUT_CYCLES.
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [4:0] char3,
    output logic [4:0] char2,
    output logic [4:0] char1,
    output logic [4:0] char0,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       anode_err,
    output logic       frame_timeout
);

    localparam int                CNT_W     = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]        CODE_BLANK = 5'd20;
    localparam logic              ST_SETTLE = 1'b0;
    localparam logic              ST_HOLD   = 1'b1;

    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [CNT_W-1:0] stab_cnt, stab_cnt_nxt;
    logic             state;
    logic [3:0]       mask;
    logic [19:0]      slots;
    logic [19:0]      prev_frame;
    logic [TO_W-1:0]  to_cnt;

    logic       same;
    logic       legal;
    logic       illegal;
    logic [1:0] slot_idx;
    logic [4:0] glyph;
    logic       capture;
    logic       complete;
    logic       timeout_hit;

    // Table is written in abcdefg order, so the bus is reversed before lookup.
    function automatic logic [4:0] decode(input logic [6:0] abcdefg);
        case (abcdefg)
            7'b0000001: decode = 5'd0;
            7'b1001111: decode = 5'd1;
            7'b0010010: decode = 5'd2;
            7'b0000110: decode = 5'd3;
            7'b1001100: decode = 5'd4;
            7'b0100100: decode = 5'd5;
            7'b0100000: decode = 5'd6;
            7'b0001111: decode = 5'd7;
            7'b0000000: decode = 5'd8;
            7'b0000100: decode = 5'd9;
            7'b0001000: decode = 5'd10;
            7'b1100000: decode = 5'd11;
            7'b0110001: decode = 5'd12;
            7'b1000010: decode = 5'd13;
            7'b0110000: decode = 5'd14;
            7'b0111000: decode = 5'd15;
            7'b1110001: decode = 5'd16;
            7'b1101010: decode = 5'd17;
            7'b0011000: decode = 5'd18;
            7'b1000001: decode = 5'd19;
            7'b1111111: decode = 5'd20;
            default:    decode = 5'd31;
        endcase
    endfunction

    always_comb begin
        legal    = 1'b1;
        slot_idx = 2'd0;
        case (an_q)
            4'b1110: slot_idx = 2'd0;
            4'b1101: slot_idx = 2'd1;
            4'b1011: slot_idx = 2'd2;
            4'b0111: slot_idx = 2'd3;
            default: legal = 1'b0;
        endcase
        illegal = !legal && (an_q != 4'b1111);

        same = (an_q == an_d) && (seg_q == seg_d);
        if (!same)
            stab_cnt_nxt = '0;
        else if (stab_cnt == CNT_MAX)
            stab_cnt_nxt = stab_cnt;
        else
            stab_cnt_nxt = stab_cnt + 1'b1;

        glyph = decode({seg_q[0], seg_q[1], seg_q[2], seg_q[3], seg_q[4], seg_q[5], seg_q[6]});
        // The count value reached this cycle already includes the current sample.
        capture     = (state == ST_SETTLE) && legal && same && (stab_cnt_nxt == SETTLE_M1);
        complete    = (mask == 4'b1111);
        timeout_hit = (to_cnt == TO_LAST) && !complete;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            an_q          <= 4'b1111;
            an_d          <= 4'b1111;
            seg_q         <= 7'h7f;
            seg_d         <= 7'h7f;
            stab_cnt      <= '0;
            state         <= ST_SETTLE;
            mask          <= 4'b0000;
            slots         <= {4{CODE_BLANK}};
            prev_frame    <= {4{CODE_BLANK}};
            to_cnt        <= '0;
            char3         <= CODE_BLANK;
            char2         <= CODE_BLANK;
            char1         <= CODE_BLANK;
            char0         <= CODE_BLANK;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            anode_err     <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            an_q     <= an;
            seg_q    <= seg;
            an_d     <= an_q;
            seg_d    <= seg_q;
            stab_cnt <= stab_cnt_nxt;

            if (state == ST_SETTLE && capture)
                state <= ST_HOLD;
            else if (state == ST_HOLD && !same)
                state <= ST_SETTLE;

            // A new illegal pattern (from legal, idle or another illegal one) pulses once.
            anode_err     <= illegal && (an_q != an_d);
            frame_valid   <= complete;
            frame_timeout <= timeout_hit;

            if (capture)
                slots[5*slot_idx +: 5] <= glyph;

            if (complete || timeout_hit)
                mask <= 4'b0000;
            else if (capture)
                mask <= mask | (4'b0001 << slot_idx);

            if (complete) begin
                char3         <= slots[19:15];
                char2         <= slots[14:10];
                char1         <= slots[9:5];
                char0         <= slots[4:0];
                frame_changed <= (slots != prev_frame);
                prev_frame    <= slots;
            end else begin
                frame_changed <= 1'b0;
            end

            if (complete || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench: scans glyph strings onto the anode/cathode bus and checks the decoded frames.
module tb_seg7_scan_decoder;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic [3:0] an;
    logic [4:0] char3, char2, char1, char0;
    logic       frame_valid, frame_changed, anode_err, frame_timeout;

    seg7_scan_decoder #(
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(200),
        .TO_W          (8)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .seg          (seg),
        .an           (an),
        .char3        (char3),
        .char2        (char2),
        .char1        (char1),
        .char0        (char0),
        .frame_valid  (frame_valid),
        .frame_changed(frame_changed),
        .anode_err    (anode_err),
        .frame_timeout(frame_timeout)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Glyphs in abcdefg order, active-low.
    localparam logic [6:0] G_0 = 7'b0000001, G_1 = 7'b1001111, G_3 = 7'b0000110, G_8 = 7'b0000000;
    localparam logic [6:0] G_C = 7'b0110001, G_U = 7'b1000001, G_P = 7'b0011000, G_D = 7'b1000010;
    localparam logic [6:0] G_N = 7'b1101010, G_E = 7'b0110000, G_F = 7'b0111000, G_L = 7'b1110001;
    localparam logic [6:0] G_BL = 7'b1111111, G_UNK = 7'b0111111;

    localparam logic [27:0] T_CUP3 = {G_C, G_U, G_P, G_3};
    localparam logic [27:0] T_DONE = {G_D, G_0, G_N, G_E};
    localparam logic [27:0] T_FILL = {G_F, G_1, G_L, G_L};
    localparam logic [27:0] T_UNK  = {G_8, G_8, G_BL, G_UNK};
    localparam logic [27:0] T_8888 = {G_8, G_8, G_8, G_8};

    typedef struct {
        logic [27:0] txt;
        int          dwell;
        int          e3, e2, e1, e0;
        int          ech;
    } vec_t;

    vec_t        vecs[7];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    logic [20:0] frames_q[$];
    int          to_cycles[$];

    always @(negedge clk_100MHz) begin
        cyc++;
        if (frame_valid)   frames_q.push_back({char3, char2, char1, char0, frame_changed});
        if (frame_timeout) to_cycles.push_back(cyc);
        if (anode_err)     err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #2;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] to_seg(input logic [6:0] abcdefg);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = abcdefg[6-i];
        return r;
    endfunction

    // The driver moves the anode first and updates the cathodes one cycle later.
    task automatic scan(input logic [27:0] txt, input int first, input int last, input int dwell);
        logic [3:0] one;
        one = 4'b0001;
        for (int d = first; d <= last; d++) begin
            an = ~(one << d);
            tick(1);
            seg = to_seg(txt[7*d +: 7]);
            tick(dwell - 1);
        end
    endtask

    task automatic gap();
        an = 4'b1111;
        tick(1);
        seg = 7'h7f;
        tick(3);
    endtask

    task automatic chk_frame(input string tag, input int e3, input int e2, input int e1, input int e0, input int ech);
        logic [20:0] f;
        chk({tag, " frames"}, frames_q.size(), 1);
        if (frames_q.size() > 0) begin
            f = frames_q.pop_front();
            chk({tag, " char3"}, f[20:16], e3);
            chk({tag, " char2"}, f[15:11], e2);
            chk({tag, " char1"}, f[10:6], e1);
            chk({tag, " char0"}, f[5:1], e0);
            chk({tag, " changed"}, f[0], ech);
        end
        frames_q.delete();
    endtask

    initial begin
        vecs[0] = '{T_CUP3, 40, 12, 19, 18, 3, 1};
        vecs[1] = '{T_CUP3, 40, 12, 19, 18, 3, 0};
        vecs[2] = '{T_DONE, 40, 13, 0, 17, 14, 1};
        vecs[3] = '{T_FILL, 40, 15, 1, 16, 16, 1};
        vecs[4] = '{T_UNK,  40, 8, 8, 20, 31, 1};
        vecs[5] = '{T_8888, 17, 8, 8, 8, 8, 1};
        vecs[6] = '{T_8888, 17, 8, 8, 8, 8, 0};

        reset = 1'b1;
        an    = 4'b1111;
        seg   = 7'h7f;
        tick(3);
        chk("reset char3", char3, 20);
        chk("reset char2", char2, 20);
        chk("reset char1", char1, 20);
        chk("reset char0", char0, 20);
        chk("reset frame_valid", frame_valid, 0);
        chk("reset frame_changed", frame_changed, 0);
        chk("reset anode_err", anode_err, 0);
        chk("reset frame_timeout", frame_timeout, 0);
        reset = 1'b0;
        tick(2);
        frames_q.delete();

        for (int i = 0; i < 7; i++) begin
            scan(vecs[i].txt, 0, 3, vecs[i].dwell);
            gap();
            chk_frame($sformatf("vec%0d", i), vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].ech);
        end
        chk("no anode_err on legal scans", err_cnt, 0);

        // Dwell shorter than the settle window: nothing captured, timeouts every 200 cycles.
        to_cycles.delete();
        for (int r = 0; r < 12; r++) begin
            scan(T_CUP3, 0, 3, 10);
            gap();
        end
        chk("short dwell frames", frames_q.size(), 0);
        chk("short dwell timeouts>=2", int'(to_cycles.size() >= 2), 1);
        for (int i = 1; i < to_cycles.size(); i++)
            chk($sformatf("timeout spacing %0d", i), to_cycles[i] - to_cycles[i-1], 200);
        chk("hold char3 after timeout", char3, 8);
        chk("hold char0 after timeout", char0, 8);

        frames_q.delete();
        for (int r = 0; r < 3 && frames_q.size() == 0; r++) begin
            scan(T_CUP3, 0, 3, 17);
            gap();
        end
        chk("dwell17 resumes", int'(frames_q.size() >= 1), 1);
        if (frames_q.size() > 0) begin
            while (frames_q.size() > 1) void'(frames_q.pop_back());
            chk_frame("dwell17", 12, 19, 18, 3, 1);
        end

        // Illegal anode patterns mid-scan after a realigning reset.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        frames_q.delete();
        err_cnt = 0;
        scan(T_DONE, 0, 1, 30);
        an = 4'b0011;
        tick(30);
        chk("anode_err 0011 once", err_cnt, 1);
        an = 4'b0101;
        tick(5);
        chk("anode_err 0101 again", err_cnt, 2);
        scan(T_DONE, 2, 3, 30);
        gap();
        chk_frame("illegal", 13, 0, 17, 14, 1);

        // Reset after two captures must drop them.
        scan(T_CUP3, 0, 1, 20);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("midreset char3", char3, 20);
        chk("midreset char2", char2, 20);
        chk("midreset char1", char1, 20);
        chk("midreset char0", char0, 20);
        frames_q.delete();
        scan(T_CUP3, 2, 3, 20);
        gap();
        chk("two captures after reset no frame", frames_q.size(), 0);
        scan(T_CUP3, 0, 3, 20);
        gap();
        chk_frame("after reset", 12, 19, 18, 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
